// File: rtl/key_debounce.sv
// key_debounce: per-key bounce filter with sticky press/release events packed for CPU readout.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to add held-key auto-repeat press pulses.
module key_debounce #(
    parameter int KEY_WIDTH       = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int CNT_WIDTH       = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KEY_WIDTH-1:0]  key_in,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] clear_mask,
    output logic [KEY_WIDTH-1:0]  key_state,
    output logic [KEY_WIDTH-1:0]  press_pulse,
    output logic [KEY_WIDTH-1:0]  release_pulse,
    output logic [DATA_WIDTH-1:0] data
);
    localparam int EVT_W = 3 * KEY_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt_q [KEY_WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [KEY_WIDTH];
    logic [KEY_WIDTH-1:0] state_q, state_d, rise_d, fall_d;
    logic [KEY_WIDTH-1:0] press_q, press_d, release_q;
    logic [KEY_WIDTH-1:0] press_evt_q, press_evt_d, release_evt_q, release_evt_d;
    logic [KEY_WIDTH-1:0] repeat_w, press_clr_w, release_clr_w;
    logic [EVT_W-1:0]     mask_w;
    logic                 unused_mask;

    always_comb begin
        for (int i = 0; i < KEY_WIDTH; i++) begin
            cnt_d[i]  = (key_in[i] == state_q[i] || cnt_q[i] == CNT_LAST) ? '0 : cnt_q[i] + 1'b1;
            rise_d[i] = key_in[i] & ~state_q[i] & (cnt_q[i] == CNT_LAST);
            fall_d[i] = ~key_in[i] & state_q[i] & (cnt_q[i] == CNT_LAST);
        end
    end

    // Mask bits map onto data positions; the key_state field and padding are ignored.
    assign mask_w        = EVT_W'(clear_mask);
    assign press_clr_w   = {KEY_WIDTH{clear}} & mask_w[KEY_WIDTH +: KEY_WIDTH];
    assign release_clr_w = {KEY_WIDTH{clear}} & mask_w[2*KEY_WIDTH +: KEY_WIDTH];
    assign unused_mask   = ^{clear_mask, mask_w[KEY_WIDTH-1:0]};

    assign state_d       = (state_q | rise_d) & ~fall_d;
    assign press_d       = rise_d | repeat_w;
    // A pulse arriving with a clear still sets the bit, so no event is lost.
    assign press_evt_d   = press_q | (press_evt_q & ~press_clr_w);
    assign release_evt_d = release_q | (release_evt_q & ~release_clr_w);

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_q [KEY_WIDTH];
    logic [RPT_W-1:0] rpt_d [KEY_WIDTH];

    // Reloading to DELAY-PERIOD makes every later repeat land PERIOD cycles apart.
    always_comb begin
        for (int i = 0; i < KEY_WIDTH; i++) begin
            repeat_w[i] = state_q[i] & ~fall_d[i] & (rpt_q[i] == RPT_LAST);
            rpt_d[i]    = (~state_q[i] | rise_d[i]) ? '0 : repeat_w[i] ? RPT_RELOAD : rpt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < KEY_WIDTH; i++) rpt_q[i] <= '0;
        end else begin
            for (int i = 0; i < KEY_WIDTH; i++) rpt_q[i] <= rpt_d[i];
        end
    end
`else
    assign repeat_w = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < KEY_WIDTH; i++) cnt_q[i] <= '0;
            state_q       <= '0;
            press_q       <= '0;
            release_q     <= '0;
            press_evt_q   <= '0;
            release_evt_q <= '0;
        end else begin
            for (int i = 0; i < KEY_WIDTH; i++) cnt_q[i] <= cnt_d[i];
            state_q       <= state_d;
            press_q       <= press_d;
            release_q     <= fall_d;
            press_evt_q   <= press_evt_d;
            release_evt_q <= release_evt_d;
        end
    end

    assign key_state     = state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign data          = DATA_WIDTH'({release_evt_q, press_evt_q, state_q});
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scoreboard bench for key_debounce (12-bit and truncated 8-bit data views).
module tb_key_debounce;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int DEB = 2;
`else
    localparam int DEB = 4;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  key_in = '0;
    logic        clear = 1'b0;
    logic [11:0] clear_mask = '0;
    logic [3:0]  key_state, press_pulse, release_pulse;
    logic [11:0] data;
    logic [3:0]  ks8, pp8, rp8;
    logic [7:0]  data8;

    typedef struct {
        string       tag;
        logic [3:0]  ks, pp, rp;
        logic [11:0] d;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    key_debounce #(.KEY_WIDTH(4), .DATA_WIDTH(12), .CNT_WIDTH(8), .DEBOUNCE_CYCLES(DEB),
                   .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .clear(clear), .clear_mask(clear_mask),
        .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse), .data(data)
    );

    key_debounce #(.KEY_WIDTH(4), .DATA_WIDTH(8), .CNT_WIDTH(8), .DEBOUNCE_CYCLES(DEB),
                   .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut8 (
        .clk(clk), .reset(reset), .key_in(key_in), .clear(clear), .clear_mask(clear_mask[7:0]),
        .key_state(ks8), .press_pulse(pp8), .release_pulse(rp8), .data(data8)
    );

    task automatic expect_out(input string tag, input logic [3:0] ks, pp, rp, pe, re);
        exp_t e;
        e.tag = tag;
        e.ks  = ks;
        e.pp  = pp;
        e.rp  = rp;
        e.d   = {re, pe, ks};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            assert (key_state === e.ks) else begin
                fails++;
                $error("FAIL %s key_state got %h want %h", e.tag, key_state, e.ks);
            end
            tests++;
            assert (press_pulse === e.pp) else begin
                fails++;
                $error("FAIL %s press_pulse got %h want %h", e.tag, press_pulse, e.pp);
            end
            tests++;
            assert (release_pulse === e.rp) else begin
                fails++;
                $error("FAIL %s release_pulse got %h want %h", e.tag, release_pulse, e.rp);
            end
            tests++;
            assert (data === e.d) else begin
                fails++;
                $error("FAIL %s data got %h want %h", e.tag, data, e.d);
            end
            tests++;
            assert (data8 === e.d[7:0]) else begin
                fails++;
                $error("FAIL %s data8 got %h want %h", e.tag, data8, e.d[7:0]);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        tick(2);
        expect_out("reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        check_out();
        reset  = 1'b1;
        key_in = 4'b0001;
        expect_out("ar_pre", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_out();
        for (int k = 0; k < 31; k++) begin
            if (k == 22) key_in = 4'b0000;
            expect_out("autorepeat", {3'b0, k < 23}, {3'b0, k == 0 || k == 10 || k == 15 || k == 20},
                       {3'b0, k == 23}, {3'b0, k >= 1}, {3'b0, k >= 24});
            tick(1);
            check_out();
        end
`else
        int bnc[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        key_in = 4'hF;
        tick(2);
        expect_out("reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        check_out();
        reset = 1'b1;
        expect_out("hold_pre", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(3);
        check_out();
        expect_out("press_all", 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_out();
        expect_out("press_evt", 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
        tick(1);
        check_out();
        for (int k = 0; k < 12; k++) begin
            expect_out("held_no_repeat", 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
            tick(1);
            check_out();
        end
        clear      = 1'b1;
        clear_mask = 12'h00F;
        expect_out("clr_state_field", 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
        tick(1);
        check_out();
        clear_mask = 12'h000;
        expect_out("clr_zero_mask", 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
        tick(1);
        check_out();
        clear_mask = 12'h0A0;
        expect_out("clr_partial", 4'hF, 4'h0, 4'h0, 4'h5, 4'h0);
        tick(1);
        check_out();
        clear_mask = 12'h050;
        expect_out("clr_rest", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_out();
        clear      = 1'b0;
        clear_mask = 12'h000;
        key_in     = 4'b1011;
        expect_out("rel_pre", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(3);
        check_out();
        expect_out("release", 4'hB, 4'h0, 4'h4, 4'h0, 4'h0);
        tick(1);
        check_out();
        expect_out("release_evt", 4'hB, 4'h0, 4'h0, 4'h0, 4'h4);
        tick(1);
        check_out();
        clear      = 1'b1;
        clear_mask = 12'h400;
        expect_out("clr_release", 4'hB, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_out();
        clear      = 1'b0;
        clear_mask = 12'h000;
        key_in     = 4'h0;
        expect_out("rel_all", 4'h0, 4'h0, 4'hB, 4'h0, 4'h0);
        tick(4);
        check_out();
        clear      = 1'b1;
        clear_mask = 12'hFFF;
        expect_out("clr_vs_set_rel", 4'h0, 4'h0, 4'h0, 4'h0, 4'hB);
        tick(1);
        check_out();
        expect_out("clr_all", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_out();
        clear      = 1'b0;
        clear_mask = 12'h000;
        for (int k = 0; k < 8; k++) begin
            key_in[0] = bnc[k][0];
            if (k < 7) expect_out("bounce", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
            else expect_out("bounce_rise", 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
            tick(1);
            check_out();
        end
        expect_out("bounce_evt", 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        tick(1);
        check_out();
        key_in = 4'b0011;
        expect_out("k1_pre", 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        tick(3);
        check_out();
        expect_out("k1_rise", 4'h3, 4'h2, 4'h0, 4'h1, 4'h0);
        tick(1);
        check_out();
        clear      = 1'b1;
        clear_mask = 12'h030;
        expect_out("clr_collide", 4'h3, 4'h0, 4'h0, 4'h2, 4'h0);
        tick(1);
        check_out();
        clear_mask = 12'h020;
        expect_out("clr_after", 4'h3, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_out();
        clear      = 1'b0;
        clear_mask = 12'h000;
        key_in     = 4'b0111;
        expect_out("k2_count", 4'h3, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(2);
        check_out();
        #1 reset = 1'b0;
        #1;
        expect_out("async_rst", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        check_out();
        tick(1);
        reset = 1'b1;
        expect_out("restart_pre", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(3);
        check_out();
        expect_out("restart_rise", 4'h7, 4'h7, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_out();
        expect_out("restart_evt", 4'h7, 4'h0, 4'h0, 4'h7, 4'h0);
        tick(1);
        check_out();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Per-key debouncer and press-event latch, directly downstream of the board key input stage.
- Consumes the synchronized, active-high key levels produced by that stage and filters contact bounce with a per-key stability counter.
- Tracks a debounced key state and latches sticky press/release events, which the CPU reads and clears via a mask-clear handshake.
- Output packs events and state into one DATA_WIDTH word for the CPU's I/O read mux.

Parameters:
- KEY_WIDTH, 4: number of keys.
- DATA_WIDTH, 8: width of packed data output; must be >= 3*KEY_WIDTH or upper fields are truncated (see packing).
- CNT_WIDTH, 20: width of each per-key stability counter.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new level; 1 <= DEBOUNCE_CYCLES < 2**CNT_WIDTH.
- REPEAT_DELAY, 25000000: cycles held before the first auto-repeat (used only with optional feature).
- REPEAT_PERIOD, 5000000: cycles between auto-repeats (used only with optional feature).

Ports:
- clk  input  1  system clock, single clock domain.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- key_in  input  KEY_WIDTH  synchronized key levels, 1 = pressed.
- clear  input  1  one-cycle strobe; clears event bits selected by clear_mask.
- clear_mask  input  DATA_WIDTH  bit positions within data to clear; only event-field bits have effect.
- key_state  output  KEY_WIDTH  debounced level, 1 = pressed.
- press_pulse  output  KEY_WIDTH  one-cycle pulse on accepted 0->1.
- release_pulse  output  KEY_WIDTH  one-cycle pulse on accepted 1->0.
- data  output  DATA_WIDTH  packed {release_evt, press_evt, key_state}; LSBs = key_state, zero-filled above 3*KEY_WIDTH.

Behaviour:
- Reset (reset=0, asynchronous): all counters = 0; key_state = 0; press_evt = 0; release_evt = 0; both pulse outputs = 0; data = 0.
- Each key is independent. Let raw = key_in[i] and st = key_state[i]:
  - raw == st: cnt <= 0.
  - raw != st and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - raw != st and cnt == DEBOUNCE_CYCLES-1: st <= raw; cnt <= 0; the matching pulse is registered for that same edge.
- Latency: a clean level change appears on key_state exactly DEBOUNCE_CYCLES clock edges after key_in changes. With DEBOUNCE_CYCLES=1, the latency is 1 cycle.
- Bounce: any return of raw to st before the threshold zeroes the counter, and no state change occurs.
- press_pulse and release_pulse are registered. Each is high for exactly one cycle, coincident with the first cycle of the new key_state.
- Sticky event bits:
  - press_evt[i] is set on press_pulse[i]; release_evt[i] is set on release_pulse[i].
  - Bits are cleared on clear=1 when the corresponding clear_mask bit is 1. Clear masks are at bit KEY_WIDTH+i for press and 2*KEY_WIDTH+i for release.
  - Set and clear in the same cycle: set wins (the bit remains 1), so no event is lost.
  - clear with a zero mask, or with mask bits only in the key_state/pad field, has no effect.
- data is registered from the current event and state regs (no extra latency beyond those regs).
- Counters never exceed DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Reset mid-count discards the partial count; after release, debounce restarts from 0 against key_state=0. A key held through reset therefore yields a press event DEBOUNCE_CYCLES cycles after reset deasserts.

Optional Feature:
- Macro: KEY_DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - Each key has an extra repeat counter, cleared whenever key_state[i]=0 or on press_pulse[i].
  - While key_state[i]=1, the counter increments. On reaching REPEAT_DELAY-1, press_pulse[i] fires again (setting press_evt[i]) and the counter reloads so that subsequent repeats occur every REPEAT_PERIOD cycles.
  - Releasing the key stops repeats immediately.
  - No release events are generated by repeats.
- Undefined: no repeat logic is synthesized, and press_pulse fires only on debounced 0->1 edges.

Test Plan:
- Reset: reset=0 with key_in=4'b1111 -> data=0, key_state=0; after reset=1 and DEBOUNCE_CYCLES=4, key_state=4'b1111 on the 4th edge, press_pulse=4'b1111 for 1 cycle, data=8'h0F|8'hF0 (truncated press/state fields with DATA_WIDTH=8, KEY_WIDTH=4 -> data[7:4]=press_evt=4'hF, data[3:0]=4'hF).
- Bounce (DEBOUNCE_CYCLES=4): key_in[0] toggles 1,1,1,0,1,1,1,1 -> no change until 4 consecutive 1s; key_state[0] rises exactly 4 edges after the last 0->1; a single press_pulse.
- Release (DEBOUNCE_CYCLES=4): key held, then key_in[2]=0 -> release_pulse[2] after 4 edges; release_evt[2] is set (with DATA_WIDTH=12, data[10]=1).
- Clear collision: clear=1 with clear_mask bit for press_evt[1] on the same cycle as press_pulse[1] -> press_evt[1] stays 1; the next clear cycle zeroes it.
- Mid-operation reset: assert reset at count 2 of 4 -> all outputs 0 asynchronously (before the next clk edge); after release, the full 4-cycle debounce restarts.
- Auto-repeat (macro defined; REPEAT_DELAY=10, REPEAT_PERIOD=5, DEBOUNCE_CYCLES=2): hold key 0 -> press_pulse at t0, t0+10, t0+15, t0+20; release -> no further pulses.
